// File: rtl/zacore_wb_arb.sv
// Writeback arbiter: picks one completed result per cycle and registers it onto the regfile write port.
// Define ZACORE_WB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest source wins).
module zacore_wb_arb #(
  parameter int N_SRC = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_SRC-1:0]     i_src_valid,
  input  logic [5*N_SRC-1:0]   i_src_rd_index,
  input  logic [32*N_SRC-1:0]  i_src_data,
  output logic [N_SRC-1:0]     o_src_ready,
  output logic [4:0]           o_rd_index,
  output logic [31:0]          o_rd,
  output logic                 o_rd_write_enable,
  output logic [31:0]          o_pending
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] grant;
  logic             grant_any;
  logic [PW-1:0]    grant_id;
  logic [4:0]       sel_index;
  logic [31:0]      sel_data;

`ifdef ZACORE_WB_RR_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] scan_id;

  function automatic logic [PW-1:0] wrap_id(input int s);
    if (s >= N_SRC) return PW'(s - N_SRC);
    return PW'(s);
  endfunction

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      scan_id = wrap_id(int'(ptr) + i);
      if (!grant_any && i_src_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == PW'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!grant_any && i_src_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    grant[grant_id] = grant_any;
  end

  // Ready is held low during reset so no source sees a handshake that the output stage will not record.
  assign o_src_ready = grant & {N_SRC{i_rst_n}};

  assign sel_index = i_src_rd_index[5*int'(grant_id) +: 5];
  assign sel_data  = i_src_data[32*int'(grant_id) +: 32];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_index        <= '0;
      o_rd              <= '0;
      o_rd_write_enable <= 1'b0;
    end else begin
      o_rd_write_enable <= grant_any && (sel_index != 5'd0);
      if (grant_any) begin
        o_rd_index <= sel_index;
        o_rd       <= sel_data;
      end
    end
  end

  // A result stays in the mask through its handshake cycle; afterwards regfile bypass covers it.
  always_comb begin
    o_pending = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_src_valid[k]) o_pending[i_src_rd_index[5*k +: 5]] = 1'b1;
    end
    o_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_zacore_wb_arb.sv
// Scoreboard bench for zacore_wb_arb: a source model drives results, expected writes are queued per handshake.
module tb_zacore_wb_arb;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_valid;
  logic [5*N-1:0]    src_rd_index;
  logic [32*N-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic [4:0]        rd_index;
  logic [31:0]       rd;
  logic              rd_write_enable;
  logic [31:0]       pending;

  zacore_wb_arb #(.N_SRC(N)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_src_valid       (src_valid),
    .i_src_rd_index    (src_rd_index),
    .i_src_data        (src_data),
    .o_src_ready       (src_ready),
    .o_rd_index        (rd_index),
    .o_rd              (rd),
    .o_rd_write_enable (rd_write_enable),
    .o_pending         (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          remaining[N];
  logic [4:0]  s_idx[N];
  logic [31:0] s_dat[N];
  int          m_ptr;
  logic [4:0]  m_last_idx;
  logic [31:0] m_last_dat;
  logic [N-1:0] obs_ready;
  logic [31:0] obs_pending;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input int k, input logic [4:0] idx, input logic [31:0] dat, input int cnt);
    s_idx[k] = idx;
    s_dat[k] = dat;
    remaining[k] = cnt;
  endtask

  task automatic apply_bus();
    for (int k = 0; k < N; k++) begin
      src_valid[k] = remaining[k] > 0;
      src_rd_index[5*k +: 5] = s_idx[k];
      src_data[32*k +: 32] = s_dat[k];
    end
  endtask

  function automatic int model_grant();
    int g = -1;
`ifdef ZACORE_WB_RR_EN
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (g < 0 && remaining[k] > 0) g = k;
    end
`else
    for (int i = 0; i < N; i++) if (g < 0 && remaining[i] > 0) g = i;
`endif
    return g;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int k = 0; k < N; k++) if (remaining[k] > 0) p[s_idx[k]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock: drive after the edge, check handshake at negedge, check the write 1 ns after the next edge.
  task automatic cycle();
    int g;
    wr_t e, o;
    apply_bus();
    @(negedge clk);
    g = model_grant();
    obs_ready = src_ready;
    obs_pending = pending;
    chk("ready", src_ready, (g < 0) ? 0 : (1 << g));
    chk("pending", pending, model_pending());
    if (g >= 0) begin
      e.we = (s_idx[g] != 5'd0);
      e.idx = s_idx[g];
      e.dat = s_dat[g];
      m_last_idx = s_idx[g];
      m_last_dat = s_dat[g];
      remaining[g]--;
      s_dat[g]++;
      m_ptr = (g + 1) % N;
    end else begin
      e.we = 1'b0;
      e.idx = m_last_idx;
      e.dat = m_last_dat;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      o = exp_q.pop_front();
      chk("rd_we", rd_write_enable, o.we);
      chk("rd_index", rd_index, o.idx);
      chk("rd_data", rd, o.dat);
    end
  endtask

  task automatic do_reset(input bit all_valid);
    rst_n = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    m_last_idx = '0;
    m_last_dat = '0;
    for (int k = 0; k < N; k++) present(k, 5'd0, 32'd0, 0);
    if (all_valid) for (int k = 0; k < N; k++) present(k, 5'(k + 1), 32'h100 + k, 1);
    apply_bus();
    #1;
    chk("rst_async_we", rd_write_enable, 0);
    chk("rst_async_idx", rd_index, 0);
    chk("rst_async_rd", rd, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", src_ready, 0);
      chk("rst_we", rd_write_enable, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit any_remaining();
    for (int k = 0; k < N; k++) if (remaining[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int budget = 0;
    while (any_remaining() && budget < 40) begin
      cycle();
      budget++;
    end
    chk("drain_timeout", any_remaining(), 0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[6];
    rst_n = 1'b1;
    src_valid = '0;
    src_rd_index = '0;
    src_data = '0;
    #3;

    // Reset held with every source valid; first grant after release must go to source 0.
    do_reset(1'b1);
    cycle();
    chk("first_grant", obs_ready, 3'b001);
    drain();

    // Lone source 1 writing x5.
    present(1, 5'd5, 32'hDEADBEEF, 1);
    cycle();
    chk("s1_ready", obs_ready, 3'b010);
    chk("s1_pending5", obs_pending[5], 1);
    chk("s1_we", rd_write_enable, 1);
    chk("s1_idx", rd_index, 5);
    chk("s1_data", rd, 32'hDEADBEEF);
    cycle();
    chk("s1_pending5_after", obs_pending[5], 0);

    // All three sources continuously valid.
`ifdef ZACORE_WB_RR_EN
    seq = '{0, 1, 2, 0, 1, 2};
`else
    seq = '{0, 0, 0, 0, 0, 0};
`endif
    present(0, 5'd1, 32'hA000_0000, 6);
    present(1, 5'd2, 32'hB000_0000, 6);
    present(2, 5'd3, 32'hC000_0000, 6);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("grant_seq", obs_ready, 1 << seq[i]);
      chk("no_bubble", rd_write_enable, 1);
`ifndef ZACORE_WB_RR_EN
      chk("pend23", obs_pending[3:2], 2'b11);
`endif
    end
    drain();

    // Write to x0: handshake completes, no strobe, no pending bit.
    present(2, 5'd0, 32'h12345678, 1);
    cycle();
    chk("x0_ready", obs_ready, 3'b100);
    chk("x0_pending", obs_pending, 0);
    chk("x0_we", rd_write_enable, 0);
    cycle();

    // Same destination from two sources: both granted, later one lands last.
    present(0, 5'd7, 32'h0000_AAAA, 1);
    present(1, 5'd7, 32'h0000_BBBB, 1);
    cycle();
    cycle();
    chk("same_idx_last", rd, 32'h0000_BBBB);
    cycle();

    // Random traffic.
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < N; k++)
        if (remaining[k] == 0 && $urandom_range(0, 2) == 0)
          present(k, 5'($urandom_range(0, 31)), $urandom, int'($urandom_range(1, 3)));
      cycle();
    end
    drain();

    // Async reset while a write is on the port; pointer must restart at source 0.
    present(0, 5'd4, 32'h4444_0000, 1);
    cycle();
    chk("pre_rst_we", rd_write_enable, 1);
    #2;
    do_reset(1'b0);
    present(0, 5'd9, 32'h9999_0000, 1);
    present(1, 5'd10, 32'h1010_0000, 1);
    cycle();
    chk("post_rst_grant", obs_ready, 3'b001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
